// File: rtl/iq_mix_arbiter_if.sv
// Handshake/data bundle for iq_mix_arbiter: sample input side, NCO/gain inputs,
// buffered mixed output side and framing-error status.
interface iq_mix_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int NCO_W  = 17,
    parameter int AMP_W  = 16,
    localparam int OUT_W = DATA_W + NCO_W + 1
);
    logic              in_valid;
    logic              in_ready;
    logic              in_first;
    logic [DATA_W-1:0] data_in;
    logic [NCO_W-1:0]  cos;
    logic [NCO_W-1:0]  sin;
    logic [AMP_W-1:0]  amp_scale;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              frame_err;
    logic              err_clr;

    modport slave (
        input  in_valid, in_first, data_in, cos, sin, amp_scale, out_ready, err_clr,
        output in_ready, out_valid, out_data, frame_err
    );

    modport master (
        output in_valid, in_first, data_in, cos, sin, amp_scale, out_ready, err_clr,
        input  in_ready, out_valid, out_data, frame_err
    );
endinterface

// File: rtl/iq_mix_arbiter.sv
// Q/I deinterleaver + offset-binary conversion + NCO mixer (i*cos - q*sin) feeding a
// credit-guarded output FIFO. Optional amplitude scaling stage under IQ_AMP_SCALE_EN.
module iq_mix_arbiter #(
    parameter int DATA_W     = 16,
    parameter int NCO_W      = 17,
    parameter int AMP_W      = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int OUT_W     = DATA_W + NCO_W + 1
) (
    input  logic            M100CLK,
    input  logic            reset,
    iq_mix_arbiter_if.slave bus
);
    localparam int PROD_W = DATA_W + NCO_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {PH_Q, PH_I} phase_t;

    phase_t              r_phase;
    logic [DATA_W-1:0]   r_q;
    logic                r_frame_err;
    logic                r_in_ready;

    logic                w_accept;
    logic                w_launch;
    logic                w_err_set;

    assign w_accept  = bus.in_valid & r_in_ready;
    assign w_launch  = w_accept & (r_phase == PH_I) & ~bus.in_first;
    assign w_err_set = w_accept & ((r_phase == PH_Q) ? ~bus.in_first : bus.in_first);

    // A repeated Q while waiting for I replaces the held Q rather than pairing it.
    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            r_phase     <= PH_Q;
            r_q         <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_accept) begin
                case (r_phase)
                    PH_Q: begin
                        r_q     <= bus.data_in;
                        r_phase <= PH_I;
                    end
                    PH_I: begin
                        if (bus.in_first) r_q <= bus.data_in;
                        else              r_phase <= PH_Q;
                    end
                    default: r_phase <= PH_Q;
                endcase
            end
            if (w_err_set)        r_frame_err <= 1'b1;
            else if (bus.err_clr) r_frame_err <= 1'b0;
        end
    end

    // S1: offset binary -> two's complement, NCO sampled with the I sample
    logic                r_s1_valid;
    logic [DATA_W-1:0]   r_s1_i, r_s1_q;
    logic [NCO_W-1:0]    r_s1_cos, r_s1_sin;

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_i     <= '0;
            r_s1_q     <= '0;
            r_s1_cos   <= '0;
            r_s1_sin   <= '0;
        end else begin
            r_s1_valid <= w_launch;
            if (w_launch) begin
                r_s1_i   <= {~bus.data_in[DATA_W-1], bus.data_in[DATA_W-2:0]};
                r_s1_q   <= {~r_q[DATA_W-1], r_q[DATA_W-2:0]};
                r_s1_cos <= bus.cos;
                r_s1_sin <= bus.sin;
            end
        end
    end

    // S2: signed products; operands sign-extended so a same-width multiply is exact
    logic [PROD_W-1:0]   w_i_ext, w_q_ext, w_cos_ext, w_sin_ext;
    logic [PROD_W-1:0]   w_prod_i, w_prod_q;
    logic                r_s2_valid;
    logic [PROD_W-1:0]   r_s2_pi, r_s2_pq;

    assign w_i_ext   = {{NCO_W{r_s1_i[DATA_W-1]}}, r_s1_i};
    assign w_q_ext   = {{NCO_W{r_s1_q[DATA_W-1]}}, r_s1_q};
    assign w_cos_ext = {{DATA_W{r_s1_cos[NCO_W-1]}}, r_s1_cos};
    assign w_sin_ext = {{DATA_W{r_s1_sin[NCO_W-1]}}, r_s1_sin};
    assign w_prod_i  = w_i_ext * w_cos_ext;
    assign w_prod_q  = w_q_ext * w_sin_ext;

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_pi    <= '0;
            r_s2_pq    <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_pi    <= w_prod_i;
            r_s2_pq    <= w_prod_q;
        end
    end

    // S3: full-precision difference
    logic [OUT_W-1:0]    w_diff;
    logic                r_s3_valid;
    logic [OUT_W-1:0]    r_s3_d;

    assign w_diff = {r_s2_pi[PROD_W-1], r_s2_pi} - {r_s2_pq[PROD_W-1], r_s2_pq};

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            r_s3_valid <= 1'b0;
            r_s3_d     <= '0;
        end else begin
            r_s3_valid <= r_s2_valid;
            r_s3_d     <= w_diff;
        end
    end

    logic                w_push_valid;
    logic [OUT_W-1:0]    w_push_data;
    logic [2:0]          w_inflight_next;

`ifdef IQ_AMP_SCALE_EN
    // Gain travels alongside its pair so it matches the cos/sin sampling point.
    logic [AMP_W-1:0]       r_s1_amp, r_s2_amp, r_s3_amp;
    logic [OUT_W+AMP_W-1:0] w_d_ext, w_amp_ext;
    logic [OUT_W-1:0]       w_scaled;
    logic [AMP_W-1:0]       w_unused_frac;
    logic                   r_s4_valid;
    logic [OUT_W-1:0]       r_s4_d;

    assign w_d_ext   = {{AMP_W{r_s3_d[OUT_W-1]}}, r_s3_d};
    assign w_amp_ext = {{OUT_W{1'b0}}, r_s3_amp};
    assign {w_scaled, w_unused_frac} = w_d_ext * w_amp_ext;

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            r_s1_amp   <= '0;
            r_s2_amp   <= '0;
            r_s3_amp   <= '0;
            r_s4_valid <= 1'b0;
            r_s4_d     <= '0;
        end else begin
            if (w_launch) r_s1_amp <= bus.amp_scale;
            r_s2_amp   <= r_s1_amp;
            r_s3_amp   <= r_s2_amp;
            r_s4_valid <= r_s3_valid;
            r_s4_d     <= w_scaled;
        end
    end

    assign w_push_valid    = r_s4_valid;
    assign w_push_data     = {~r_s4_d[OUT_W-1], r_s4_d[OUT_W-2:0]};
    assign w_inflight_next = {2'b0, w_launch} + {2'b0, r_s1_valid}
                           + {2'b0, r_s2_valid} + {2'b0, r_s3_valid};
`else
    logic w_unused_amp;
    assign w_unused_amp    = ^bus.amp_scale;
    assign w_push_valid    = r_s3_valid;
    assign w_push_data     = {~r_s3_d[OUT_W-1], r_s3_d[OUT_W-2:0]};
    assign w_inflight_next = {2'b0, w_launch} + {2'b0, r_s1_valid} + {2'b0, r_s2_valid};
`endif

    // Output FIFO: head register plus RAM behind it; r_count covers both.
    logic [OUT_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_out_valid;
    logic [OUT_W-1:0]    r_out_data;

    logic                w_pop, w_refill, w_from_mem, w_bypass, w_mem_wr;
    logic [CNT_W-1:0]    w_mem_cnt, w_count_next;
    logic [CNT_W:0]      w_occupancy;

    assign w_pop        = r_out_valid & bus.out_ready;
    assign w_mem_cnt    = r_count - CNT_W'(r_out_valid);
    assign w_refill     = ~r_out_valid | w_pop;
    assign w_from_mem   = w_refill & (w_mem_cnt != '0);
    assign w_bypass     = w_refill & ~w_from_mem & w_push_valid;
    assign w_mem_wr     = w_push_valid & ~w_bypass;
    assign w_count_next = r_count + CNT_W'(w_push_valid) - CNT_W'(w_pop);
    assign w_occupancy  = {1'b0, w_count_next} + (CNT_W+1)'(w_inflight_next);

    always_ff @(posedge M100CLK) begin
        if (w_mem_wr) r_mem[r_wr_ptr] <= w_push_data;
    end

    // in_ready reserves a slot for every launched pair, so pushes never find the FIFO full.
    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b0;
        end else begin
            if (w_from_mem) begin
                r_out_data  <= r_mem[r_rd_ptr];
                r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
                r_out_valid <= 1'b1;
            end else if (w_bypass) begin
                r_out_data  <= w_push_data;
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            if (w_mem_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_count    <= w_count_next;
            r_in_ready <= w_occupancy < (CNT_W+1)'(FIFO_DEPTH);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_iq_mix_arbiter.sv
// Directed bench for iq_mix_arbiter: vector table through the mixer, then framing,
// backpressure and mid-stream reset sequences. Expected values are hand-computed.
module tb_iq_mix_arbiter;
    localparam int DATA_W = 16;
    localparam int NCO_W  = 17;
    localparam int AMP_W  = 16;
    localparam int DEPTH  = 8;
    localparam int OUT_W  = DATA_W + NCO_W + 1;
`ifdef IQ_AMP_SCALE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iq_mix_arbiter_if #(.DATA_W(DATA_W), .NCO_W(NCO_W), .AMP_W(AMP_W)) bus ();

    iq_mix_arbiter #(
        .DATA_W(DATA_W), .NCO_W(NCO_W), .AMP_W(AMP_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .M100CLK (clk),
        .reset   (rst),
        .bus     (bus)
    );

    typedef struct {
        string             name;
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] i;
        logic [NCO_W-1:0]  c;
        logic [NCO_W-1:0]  s;
        logic [OUT_W-1:0]  exp_plain;
        logic [OUT_W-1:0]  exp_amp;
    } vec_t;

    vec_t vecs[7];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [OUT_W-1:0] sel(input logic [OUT_W-1:0] plain, input logic [OUT_W-1:0] amp);
`ifdef IQ_AMP_SCALE_EN
        sel = amp;
`else
        sel = plain;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic send(input logic first, input logic [DATA_W-1:0] d,
                        input logic [NCO_W-1:0] c, input logic [NCO_W-1:0] s);
        int n;
        @(negedge clk);
        bus.in_first = first;
        bus.data_in  = d;
        bus.cos      = c;
        bus.sin      = s;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        else begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [DATA_W-1:0] q, input logic [DATA_W-1:0] i,
                             input logic [NCO_W-1:0] c, input logic [NCO_W-1:0] s);
        send(1'b1, q, '0, '0);
        send(1'b0, i, c, s);
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus.out_valid && k < 20);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, n, cyc, seen;
        logic [OUT_W-1:0] e;

        vecs[0] = '{"v0_doc1",   16'h8000, 16'hC000, 17'd65535,  17'd0,      34'h2_3FFF_C000, 34'h2_1FFF_E000};
        vecs[1] = '{"v1_doc2",   16'hC000, 16'h8000, 17'd0,      17'd65535,  34'h1_C000_4000, 34'h1_E000_2000};
        vecs[2] = '{"v2_zero",   16'h8000, 16'h8000, 17'h0FFFF,  17'h10000,  34'h2_0000_0000, 34'h2_0000_0000};
        vecs[3] = '{"v3_minmin", 16'h8000, 16'h0000, 17'h10000,  17'd0,      34'h2_8000_0000, 34'h2_4000_0000};
        vecs[4] = '{"v4_maxd",   16'h0000, 16'h0000, 17'h10000,  17'd65535,  34'h2_FFFF_8000, 34'h2_7FFF_C000};
        vecs[5] = '{"v5_neg1",   16'h8001, 16'h8000, 17'd0,      17'd1,      34'h1_FFFF_FFFF, 34'h1_FFFF_FFFF};
        vecs[6] = '{"v6_small",  16'h8000, 16'h8003, 17'd5,      17'd7,      34'h2_0000_000F, 34'h2_0000_0007};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.data_in   = '0;
        bus.cos       = '0;
        bus.sin       = '0;
        bus.amp_scale = 16'h8000;
        bus.out_ready = 1'b1;
        bus.err_clr   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_frame_err", 64'(bus.frame_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Vector table: latency, value, and hold after pop
        for (int v = 0; v < 7; v++) begin
            send_pair(vecs[v].q, vecs[v].i, vecs[v].c, vecs[v].s);
            wait_valid(k);
            e = sel(vecs[v].exp_plain, vecs[v].exp_amp);
            check({vecs[v].name, "_lat"},  64'(k), 64'(LAT));
            check({vecs[v].name, "_data"}, 64'(bus.out_data), 64'(e));
            @(posedge clk);
            #1;
            check({vecs[v].name, "_hold"}, 64'({bus.out_valid, bus.out_data}), 64'({1'b0, e}));
        end

        // Framing: repeated Q replaces held Q
        send(1'b1, 16'h8001, '0, '0);
        send(1'b1, 16'h8002, '0, '0);
        check("fe_double_q", 64'(bus.frame_err), 64'd1);
        send(1'b0, 16'h8000, 17'd0, 17'd3);
        wait_valid(k);
        check("fe_second_q_pairs", 64'(bus.out_data), 64'(sel(34'h1_FFFF_FFFA, 34'h1_FFFF_FFFD)));
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        check("fe_clear", 64'(bus.frame_err), 64'd0);
        send(1'b0, 16'h8000, '0, '0);
        check("fe_q_without_first", 64'(bus.frame_err), 64'd1);
        bus.err_clr = 1'b1;
        send(1'b1, 16'h8000, '0, '0);
        bus.err_clr = 1'b0;
        check("fe_set_wins_over_clr", 64'(bus.frame_err), 64'd1);
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        check("fe_clear2", 64'(bus.frame_err), 64'd0);
        send(1'b0, 16'h8001, 17'd9, 17'd0);
        wait_valid(k);
        check("fe_recover_pair", 64'(bus.out_data), 64'(sel(34'h2_0000_0009, 34'h2_0000_0004)));
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: 10 pairs with consumer stalled
        bus.out_ready = 1'b0;
        for (int p = 0; p < 8; p++) send_pair(16'h8000, 16'(16'h8001 + p), 17'd2, 17'd0);
        repeat (6) @(posedge clk);
        #1;
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("bp_head_valid",   64'(bus.out_valid), 64'd1);
        fork
            begin
                for (int p = 8; p < 10; p++) send_pair(16'h8000, 16'(16'h8001 + p), 17'd2, 17'd0);
            end
            begin
                n = 0;
                cyc = 0;
                while (n < 10 && cyc < 300) begin
                    if (bus.out_valid) begin
                        check($sformatf("bp_out%0d", n), 64'(bus.out_data),
                              64'(sel(34'h2_0000_0000 + 34'(2 * (n + 1)), 34'h2_0000_0000 + 34'(n + 1))));
                        n++;
                    end
                    @(negedge clk);
                    bus.out_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                if (n < 10) check("bp_count", 64'(n), 64'd10);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("bp_no_extra", 64'(bus.out_valid), 64'd0);

        // Reset mid-stream with results in flight, FSM left in PH_I and frame_err set
        bus.out_ready = 1'b0;
        send(1'b1, 16'h8000, '0, '0);
        send(1'b1, 16'h8000, '0, '0);
        send(1'b0, 16'h8001, 17'd1, 17'd0);
        send_pair(16'h8000, 16'h8001, 17'd1, 17'd0);
        send_pair(16'h8000, 16'h8001, 17'd1, 17'd0);
        send(1'b1, 16'h8000, '0, '0);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mrst_out_data",  64'(bus.out_data),  64'd0);
        check("mrst_in_ready",  64'(bus.in_ready),  64'd0);
        check("mrst_frame_err", 64'(bus.frame_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("mrst_no_stale", 64'(seen), 64'd0);
        send_pair(vecs[0].q, vecs[0].i, vecs[0].c, vecs[0].s);
        check("mrst_fsm_ph_q", 64'(bus.frame_err), 64'd0);
        wait_valid(k);
        check("mrst_after_data", 64'(bus.out_data), 64'(sel(vecs[0].exp_plain, vecs[0].exp_amp)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
